// File: rtl/echo_delay_mc.sv
// Multi-channel feedback echo. One sample RAM holds a circular segment of
// 2**ADDR_WIDTH words per channel (word address = {channel, pointer}). The
// channels of a frame are processed one after another, RD -> CALC -> WR each,
// and all channel results are published together in DONE.
//
// Handshake: ready is high only while the FSM sits in IDLE. A frame is
// accepted on a rising CLK edge where sample_valid=1 and ready=1. A
// sample_valid seen while ready=0 is dropped and sets the sticky overrun flag.
// y_valid is a one-cycle pulse marking the cycle in which y_out is new; there
// is no back-pressure on the output side.
module echo_delay_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_CH     = 2,
  parameter int MIX_SHIFT  = 1
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         sample_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] x_in,
  input  logic [ADDR_WIDTH-1:0]        delay_len,
  input  logic [2:0]                   fb_shift,
  output logic                         ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] y_out,
  output logic                         y_valid,
  output logic                         overrun,
  output logic                         indicator
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MW    = CW + AW;
  localparam int WORDS = NUM_CH * (2 ** AW);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

  state_t                   state;
  logic [MW-1:0]            clr_addr;
  logic [AW-1:0]            ptr;
  logic [CW-1:0]            ch;
  logic                     en_lat;
  logic [AW-1:0]            dl_lat;
  logic [2:0]               fb_lat;
  logic [NUM_CH*DW-1:0]     x_lat;
  logic [NUM_CH*DW-1:0]     y_sh;
  logic signed [DW-1:0]     wr_val;

  logic signed [DW-1:0]     mem [0:WORDS-1];
  logic signed [DW-1:0]     rd_data;

  logic                     mem_we;
  logic [MW-1:0]            mem_waddr;
  logic signed [DW-1:0]     mem_wdata;
  logic [AW-1:0]            rd_ptr;
  logic [MW-1:0]            mem_raddr;

  logic signed [DW-1:0]     x_c;
  logic signed [DW-1:0]     wet;
  logic signed [DW-1:0]     fbv;
  logic signed [DW:0]       s_ext;
  logic signed [DW:0]       f_ext;
  logic signed [DW-1:0]     s_sat;
  logic signed [DW-1:0]     f_val;

  // Clamp a DW+1 bit sum into the DW bit signed range.
  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      return v[DW-1:0];
  endfunction

  // RAM port muxing and the per-channel wet / feedback arithmetic.
  always_comb begin
    rd_ptr    = ptr - dl_lat;
    mem_raddr = {ch, rd_ptr};
    mem_we    = (state == S_CLEAR) || (state == S_WR);
    mem_waddr = (state == S_CLEAR) ? clr_addr : {ch, ptr};
    mem_wdata = (state == S_CLEAR) ? '0 : wr_val;

    x_c   = x_lat[int'(ch)*DW +: DW];
    wet   = rd_data >>> MIX_SHIFT;
    fbv   = rd_data >>> fb_lat;
    s_ext = {x_c[DW-1], x_c} + {wet[DW-1], wet};
    f_ext = {x_c[DW-1], x_c} + {fbv[DW-1], fbv};
    s_sat = sat(s_ext);
    f_val = (fb_lat == 3'd0) ? x_c : sat(f_ext);
  end

  // Sample RAM: one write port, one synchronous read port.
  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    rd_data <= mem[mem_raddr];
  end

  // Frame sequencer: clear, accept, per-channel read/compute/write, publish.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      ptr       <= '0;
      ch        <= '0;
      en_lat    <= 1'b0;
      dl_lat    <= '0;
      fb_lat    <= '0;
      x_lat     <= '0;
      y_sh      <= '0;
      wr_val    <= '0;
      ready     <= 1'b0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      overrun   <= 1'b0;
      indicator <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (sample_valid && !ready)
        overrun <= 1'b1;

      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == MW'(WORDS - 1)) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (sample_valid) begin
            x_lat  <= x_in;
            en_lat <= en;
            dl_lat <= delay_len;
            fb_lat <= fb_shift;
            ch     <= '0;
            ready  <= 1'b0;
            state  <= S_RD;
          end
        end
        S_RD: begin
          state <= S_CALC;
        end
        S_CALC: begin
          wr_val                  <= en_lat ? f_val : '0;
          y_sh[int'(ch)*DW +: DW] <= en_lat ? s_sat : x_c;
          state                   <= S_WR;
        end
        S_WR: begin
          if (ch == CW'(NUM_CH - 1)) begin
            state <= S_DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_RD;
          end
        end
        S_DONE: begin
          y_out   <= y_sh;
          y_valid <= 1'b1;
          ptr     <= ptr + 1'b1;
          if (ptr == '1)
            indicator <= ~indicator;
          ready   <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: doc/echo_delay_mc.md
Name: echo_delay_mc

Overview:
- Parametrised multi-channel feedback echo: the next generation of the single-channel delay line.
- One internal dual-port sample RAM is shared by all channels and time-multiplexed, with a separate circular segment per channel.
- Runtime-programmable delay length, feedback shift, wet/dry bypass and saturating arithmetic; sits between the audio codec receive path and the transmit path.

Parameters:
DATA_WIDTH, 32, signed sample width per channel
ADDR_WIDTH, 14, log2 of per-channel buffer depth (depth D = 2**ADDR_WIDTH)
NUM_CH, 2, number of channels; x_in/y_out are packed, channel 0 in LSBs
MIX_SHIFT, 1, wet attenuation: wet = delayed >>> MIX_SHIFT

Ports:
CLK  in  1  clock
rst  in  1  reset, asynchronous, active-low
en  in  1  1 = echo active, 0 = bypass
sample_valid  in  1  one-cycle strobe; new frame present on x_in
x_in  in  NUM_CH*DATA_WIDTH  input frame, signed per channel
delay_len  in  ADDR_WIDTH  echo delay in samples; 0 means D
fb_shift  in  3  feedback gain 2^-fb_shift; 0 = feedback off
ready  out  1  high only in IDLE; a strobe is accepted only when ready=1
y_out  out  NUM_CH*DATA_WIDTH  output frame, signed per channel
y_valid  out  1  one-cycle pulse when y_out updates
overrun  out  1  sticky; set when sample_valid arrives while ready=0
indicator  out  1  toggles each time the write pointer wraps D-1 -> 0

Behaviour:
- Reset (async, rst=0):
  - Outputs: y_out=0, y_valid=0, overrun=0, indicator=0, ready=0.
  - Internals: ptr=0, state=CLEAR.
  - A reset mid-frame abandons the frame; no partial y_out update.
- CLEAR:
  - Writes 0 to all NUM_CH*D RAM words, one word per cycle, addresses ascending.
  - Then goes to IDLE; ready=1 from the following cycle.
  - Duration: exactly NUM_CH*D cycles.
- IDLE:
  - On sample_valid=1, latch x_in, en, delay_len and fb_shift. They remain frozen for the frame.
  - Set ch=0 and go to RD.
- Per channel c, three states:
  - RD: read address = {c, (ptr - delay_len) mod D}; delay_len=0 reads {c, ptr}, i.e. the sample written D frames ago.
  - CALC: d = RAM read data (1-cycle synchronous read).
    - Wet sum: s = x_c + (d >>>MIX_SHIFT).
    - Feedback sum: f = x_c + (d >>> fb_shift); when fb_shift=0, f = x_c.
    - Both sums are computed in DATA_WIDTH+1 bits, then saturated to [-2^(DW-1), 2^(DW-1)-1].
    - Shifts are arithmetic.
  - WR: write {c, ptr} <= latched en ? f : 0. Hold y_c = latched en ? s : x_c in a shadow register.
    - If c < NUM_CH-1: c++ and go to RD; otherwise go to DONE.
- DONE:
  - y_out <= all shadow values simultaneously; y_valid=1 for this one cycle.
  - ptr <= (ptr+1) mod D; indicator toggles when ptr goes D-1 -> 0.
  - Return to IDLE.
- Latency: y_valid rises 3*NUM_CH+1 clock edges after the edge that accepted the strobe. Minimum frame spacing is 3*NUM_CH+2 cycles.
- Bypass (en=0): y = x with no saturation involved. Zeros are written and ptr still advances, so re-enabling yields no stale echo.
- Busy/CLEAR behaviour:
  - sample_valid while ready=0 is dropped, and overrun is set and held until reset.
  - sample_valid in the cycle DONE->IDLE is dropped (ready is still 0).
- delay_len and fb_shift changes take effect only at the next accepted strobe.
- Read-before-write within a channel is guaranteed: RD precedes WR in a frame, so no read-during-write hazard exists.

Test Plan:
- Config for all scenarios: NUM_CH=2, DATA_WIDTH=16, ADDR_WIDTH=4.
- After reset release: ready stays 0 for exactly 32 cycles, then 1; y_out=0, overrun=0.
- Latency/bypass: en=0, strobe with x=(ch0 100, ch1 -7) -> y_valid exactly 7 edges later, y_out=(100,-7).
- Plain echo: en=1, delay_len=3, fb_shift=0, impulse 1000 on ch0 at frame 0, then zeros -> ch0 y=1000, 0, 0, 500, then 0 forever; ch1 stays 0.
- Feedback: same as plain echo but fb_shift=1 -> ch0 y at frames 0/3/6/9 = 1000/500/250/125.
- Saturation: MIX_SHIFT=1, delay_len=1, fb_shift=0, x=32767 constant -> second frame y=32767 (not wrapped); x=-32768 constant -> second frame y=-32768.
- Overrun and wrap:
  - Strobe 2 cycles after an accepted strobe -> ignored, overrun=1 and held.
  - 16 accepted frames -> indicator toggles once.
  - delay_len=0 echoes an impulse after 16 frames.
